// File: rtl/freq_pkg.sv
// freq_pkg: shared types and default sizes for the frequency table builder and the sorter.
package freq_pkg;
   typedef enum logic [1:0] {ACCUM, DONE, CLEAR} builder_state_t;
   localparam int DEF_TABLE_SIZE   = 256;
   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_SYMBOL_WIDTH = $clog2(DEF_TABLE_SIZE);
endpackage

// File: rtl/freq_table_builder_sat_incr.sv
// sat_incr: combinational saturating increment; sat_o flags an input already at full scale.
module sat_incr #(
   parameter int W = 16
) (
   input  logic [W-1:0] val_i,
   output logic [W-1:0] inc_o,
   output logic         sat_o
);
   assign sat_o = &val_i;
   assign inc_o = sat_o ? val_i : val_i + W'(1);
endmodule

// File: rtl/freq_table_builder.sv
// freq_table_builder: counts symbols per frame into a register table, then holds it with done until acked.
module freq_table_builder
   import freq_pkg::*;
#(
   parameter  int TABLE_SIZE   = DEF_TABLE_SIZE,
   parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter  int TOTAL_WIDTH  = 24,
   localparam int SYMBOL_WIDTH = $clog2(TABLE_SIZE)
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic [SYMBOL_WIDTH-1:0]               symbol_in,
   input  logic                                  valid_in,
   input  logic                                  last_in,
   output logic                                  ready_out,
   input  logic                                  table_ack_in,
   output logic [TABLE_SIZE-1:0][DATA_WIDTH-1:0] freq_table_out,
   output logic [TOTAL_WIDTH-1:0]                total_out,
   output logic                                  sat_out,
   output logic                                  done
);
   builder_state_t                        state_q, state_d;
   logic [TABLE_SIZE-1:0][DATA_WIDTH-1:0] table_q;
   logic [TOTAL_WIDTH-1:0]                total_q, total_inc;
   logic [DATA_WIDTH-1:0]                 entry_inc;
   logic                                  entry_sat, total_sat, sat_q, done_q, ready_q, accept;

   assign accept = valid_in && ready_q;

   sat_incr #(.W(DATA_WIDTH)) u_entry_incr (
      .val_i(table_q[symbol_in]),
      .inc_o(entry_inc),
      .sat_o(entry_sat)
   );

   sat_incr #(.W(TOTAL_WIDTH)) u_total_incr (
      .val_i(total_q),
      .inc_o(total_inc),
      .sat_o(total_sat)
   );

   always_comb
      state_d = (state_q == ACCUM) ? ((accept && last_in) ? DONE : ACCUM) :
                (state_q == DONE)  ? (table_ack_in ? CLEAR : DONE) : ACCUM;

   // ready/done are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         state_q <= ACCUM;
         table_q <= '0;
         total_q <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= state_d == DONE;
         ready_q <= state_d == ACCUM;
         if (state_q == CLEAR) begin
            table_q <= '0;
            total_q <= '0;
            sat_q   <= 1'b0;
         end else if (accept) begin
            table_q[symbol_in] <= entry_inc;
            total_q            <= total_inc;
            sat_q              <= sat_q | entry_sat | total_sat;
         end
      end

   assign freq_table_out = table_q;
   assign total_out      = total_q;
   assign sat_out        = sat_q;
   assign done           = done_q;
   assign ready_out      = ready_q;
endmodule

// File: tb/tb_freq_table_builder.sv
// tb_freq_table_builder: randomized frames checked against a per-symbol count scoreboard.
module tb_freq_table_builder;
   logic             clk, rst_in;
   logic [7:0]       symbol_in;
   logic             valid_in, last_in, table_ack_in, ready_out, sat_out, done;
   logic [255:0][15:0] freq_table_out;
   logic [23:0]      total_out;
   logic [3:0]       s_sym;
   logic             s_valid, s_last, s_ack, s_ready, s_sat, s_done;
   logic [15:0][3:0] s_tbl;
   logic [4:0]       s_total;

   int n_cmp = 0, n_bad = 0;
   int cnt[256], tot;
   bit sat;
   int scnt[16], stot;
   bit ssat;

   freq_table_builder dut (
      .clk_in(clk), .rst_in(rst_in), .symbol_in(symbol_in), .valid_in(valid_in),
      .last_in(last_in), .ready_out(ready_out), .table_ack_in(table_ack_in),
      .freq_table_out(freq_table_out), .total_out(total_out), .sat_out(sat_out), .done(done)
   );

   freq_table_builder #(.TABLE_SIZE(16), .DATA_WIDTH(4), .TOTAL_WIDTH(5)) dut_s (
      .clk_in(clk), .rst_in(rst_in), .symbol_in(s_sym), .valid_in(s_valid),
      .last_in(s_last), .ready_out(s_ready), .table_ack_in(s_ack),
      .freq_table_out(s_tbl), .total_out(s_total), .sat_out(s_sat), .done(s_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void clear_model();
      foreach (cnt[i]) cnt[i] = 0;
      tot = 0;
      sat = 0;
   endfunction

   task automatic chk_table(input string tag);
      for (int i = 0; i < 256; i++)
         chk($sformatf("%s[%0d]", tag, i), 32'(freq_table_out[i]), cnt[i]);
      chk({tag, ".total"}, 32'(total_out), tot);
      chk({tag, ".sat"}, 32'(sat_out), 32'(sat));
   endtask

   // one cycle in ACCUM: ready must be high; the model counts the beat only when valid
   task automatic beat(input int s, input bit l, input bit v);
      symbol_in = 8'(s);
      last_in   = l;
      valid_in  = v;
      chk("ready_accum", 32'(ready_out), 1);
      @(negedge clk);
      if (v) begin
         sat   |= (cnt[s] == 65535) || (tot == 24'hFFFFFF);
         cnt[s] = (cnt[s] == 65535) ? cnt[s] : cnt[s] + 1;
         tot    = (tot == 24'hFFFFFF) ? tot : tot + 1;
      end
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic frame_done(input string tag);
      chk({tag, ".done"}, 32'(done), 1);
      chk({tag, ".ready"}, 32'(ready_out), 0);
      chk_table(tag);
   endtask

   task automatic ack(input string tag);
      table_ack_in = 1'b1;
      @(negedge clk);
      table_ack_in = 1'b0;
      chk({tag, ".ack_done"}, 32'(done), 0);
      chk({tag, ".ack_ready"}, 32'(ready_out), 0);
      @(negedge clk);
      clear_model();
      chk({tag, ".rearm_ready"}, 32'(ready_out), 1);
      chk_table({tag, ".cleared"});
   endtask

   task automatic beat_s(input int s, input bit l);
      s_sym   = 4'(s);
      s_last  = l;
      s_valid = 1'b1;
      chk("s_ready", 32'(s_ready), 1);
      @(negedge clk);
      ssat   |= (scnt[s] == 15) || (stot == 31);
      scnt[s] = (scnt[s] == 15) ? 15 : scnt[s] + 1;
      stot    = (stot == 31) ? 31 : stot + 1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic chk_small(input string tag);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s[%0d]", tag, i), 32'(s_tbl[i]), scnt[i]);
      chk({tag, ".total"}, 32'(s_total), stot);
      chk({tag, ".sat"}, 32'(s_sat), 32'(ssat));
      chk({tag, ".done"}, 32'(s_done), 1);
   endtask

   initial begin
      rst_in = 1'b0; symbol_in = '0; valid_in = 0; last_in = 0; table_ack_in = 0;
      s_sym = '0; s_valid = 0; s_last = 0; s_ack = 0;
      clear_model();
      #1 rst_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst.done", 32'(done), 0);
      chk_table("rst");
      rst_in = 1'b0;
      @(negedge clk);

      beat(3, 0, 1); beat(3, 0, 1); beat(7, 0, 1); beat(3, 1, 1);
      frame_done("f1");
      for (int i = 0; i < 5; i++) begin
         symbol_in = 8'd9; valid_in = 1'b1;
         @(negedge clk);
         chk("stall.ready", 32'(ready_out), 0);
         chk("stall.done", 32'(done), 1);
      end
      valid_in = 1'b0;
      chk_table("stall");
      ack("f1");

      beat(255, 1, 1);
      frame_done("single");
      ack("single");

      for (int i = 0; i < 1000; i++) begin
         while ($urandom_range(1) == 1) beat($urandom_range(255), 1'($urandom_range(1)), 0);
         beat($urandom_range(255), i == 999, 1);
      end
      frame_done("rand");
      chk("rand.total1000", 32'(total_out), 1000);
      ack("rand");

      for (int i = 0; i < 10; i++) beat($urandom_range(255), 0, 1);
      #2 rst_in = 1'b1;
      #1;
      clear_model();
      chk("async_rst.done", 32'(done), 0);
      chk_table("async_rst");
      @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);
      beat(42, 0, 1); beat(17, 0, 1); beat(42, 1, 1);
      frame_done("post_rst");
      ack("post_rst");

      foreach (scnt[i]) scnt[i] = 0;
      stot = 0; ssat = 0;
      for (int i = 0; i < 20; i++) beat_s(5, 0);
      beat_s(5, 1);
      chk_small("sat4");
      chk("sat4.entry5", 32'(s_tbl[5]), 15);
      chk("sat4.total21", 32'(s_total), 21);
      s_ack = 1'b1;
      @(negedge clk);
      s_ack = 1'b0;
      @(negedge clk);
      foreach (scnt[i]) scnt[i] = 0;
      stot = 0; ssat = 0;
      for (int i = 0; i < 40; i++) beat_s(i % 16, i == 39);
      chk_small("tot_sat");
      chk("tot_sat.total31", 32'(s_total), 31);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/freq_table_builder.md
Name: freq_table_builder

Overview:
- Upstream producer of the symbol frequency table consumed by the sorter.
- Accepts one 8-bit symbol per cycle on a valid/ready stream and increments a per-symbol saturating counter. On the last symbol of a frame it freezes and presents the complete table with a done flag.
- Holds the table until the consumer acknowledges, then clears and re-arms for the next frame.
- Sits between the byte/quantised-coefficient stream and the sorter in the Huffman table path.

Parameters:
- TABLE_SIZE, 256: number of distinct symbols; power of two; SYMBOL_WIDTH = $clog2(TABLE_SIZE).
- DATA_WIDTH, 16: width of each frequency counter.
- TOTAL_WIDTH, 24: width of the frame symbol total counter.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- symbol_in  input  SYMBOL_WIDTH  symbol value.
- valid_in  input  1  symbol_in/last_in valid.
- last_in  input  1  marks final symbol of frame; qualified by valid_in.
- ready_out  output  1  builder can accept a symbol this cycle.
- table_ack_in  input  1  consumer has captured the table; release and clear.
- freq_table_out  output  [DATA_WIDTH-1:0] x TABLE_SIZE  frequency per symbol index.
- total_out  output  TOTAL_WIDTH  symbols accepted this frame (saturating).
- sat_out  output  1  sticky: some counter or total saturated this frame.
- done  output  1  table complete and stable.

Behaviour:
- States: ACCUM, DONE, CLEAR.
- Reset (async assert) forces the following:
  - state=ACCUM; all freq_table_out entries=0; total_out=0; sat_out=0; done=0.
  - ready_out=1 from the first clock after deassert.
- ACCUM:
  - ready_out=1. A beat is accepted when valid_in&&ready_out.
  - On an accepted beat, entry[symbol_in] increments by 1 and total_out increments by 1; results are visible the next cycle.
  - Back-to-back identical symbols each count; no read-modify-write hazard is allowed (N beats of symbol s give +N).
  - Saturation: an entry at 2^DATA_WIDTH-1 stays there and sets sat_out. The same applies to total_out at 2^TOTAL_WIDTH-1.
  - An accepted beat with last_in=1 is counted, then next state is DONE.
- DONE:
  - ready_out=0 and done=1, starting the cycle after the last beat is accepted.
  - Table, total_out and sat_out are held constant. valid_in is ignored; the upstream stalls.
  - table_ack_in=1 -> next state CLEAR. table_ack_in is ignored in all other states.
- CLEAR (exactly 1 cycle):
  - done=0, ready_out=0.
  - All entries, total_out and sat_out are zeroed at the end of the cycle.
  - Next state is ACCUM.
- Latency: last beat accepted at cycle T gives done=1 at T+1. Ack at cycle A gives ready_out=1 at A+2.
- A single-symbol frame (first beat has last_in) is legal: that entry=1, total=1.
- valid_in with last_in=0 never ends a frame. last_in without valid_in has no effect.
- rst_in mid-frame or in DONE discards all counts immediately (async) and returns to ACCUM.
- Outputs are registered. freq_table_out drives the sorter input directly.
- The sorter latches the table in its idle cycle. done must therefore stay high until ack, and the table must not change while done=1.

Decomposition:
- Shared package freq_pkg holds:
  - state enum builder_state_t {ACCUM, DONE, CLEAR} (2 bits);
  - localparams SYMBOL_WIDTH, DATA_WIDTH default, TABLE_SIZE default, shared with the sorter.
- One sub-module, sat_incr: parameterised width, combinational value+1 with saturate flag.
  - Used for the addressed table entry and for total_out.
- Table storage is a register array, not BRAM, because the sorter requires full-array parallel access.

Test Plan:
- Reset, then stream symbols 3,3,7,3(last) with valid every cycle -> done at cycle after beat 4; entry[3]=3, entry[7]=1, others 0, total_out=4, sat_out=0.
- Single beat symbol 255 with last_in=1 -> entry[255]=1, total_out=1, done=1 one cycle later.
- Preload DATA_WIDTH=4 build, send symbol 5 twenty times then last -> entry[5]=15, total_out=21, sat_out=1.
- In DONE, drive valid_in=1 symbol 9 for 5 cycles -> ready_out=0, table unchanged. Pulse table_ack_in -> done=0 next cycle, all entries 0 and ready_out=1 two cycles after ack.
- Random valid_in gaps (50% duty), 1000 random symbols -> per-symbol counts match scoreboard, total_out=1000.
- Assert rst_in mid-frame after 10 beats -> entries and total_out 0 immediately (asynchronously, before the next clock edge), done=0; a new frame counts from zero.
